// File: rtl/line_fill_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_memory_if
//  Description : Line request, read-beat and write-beat bundle between the
//                cache controller (master) and its backing memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_fill_memory_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_ready;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_done;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, rsp_ready, wr_valid, wr_data,
        input  req_ready, rsp_valid, rsp_data, rsp_last, wr_ready, wr_done, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, rsp_ready, wr_valid, wr_data,
        output req_ready, rsp_valid, rsp_data, rsp_last, wr_ready, wr_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/line_fill_memory.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_memory
//  Description : Backing memory for the data cache; serves whole-line refill
//                reads and writebacks after a fixed latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_fill_memory #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 16,
    parameter int DEPTH_WORDS    = 1024,
    parameter int LATENCY        = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    line_fill_memory_if.slave  bus
);

    localparam int c_idx_w  = $clog2(DEPTH_WORDS);
    localparam int c_off_w  = $clog2(WORDS_PER_LINE);
    localparam int c_line_w = c_idx_w - c_off_w;
    localparam int c_lat_w  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [c_lat_w-1:0] c_lat_last  = (LATENCY > 0) ? c_lat_w'(LATENCY - 1) : '0;
    localparam logic [c_off_w-1:0] c_beat_last = '1;

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_wait     = 3'd1;
    localparam logic [2:0] c_st_rd_burst = 3'd2;
    localparam logic [2:0] c_st_wr_burst = 3'd3;
    localparam logic [2:0] c_st_wr_ack   = 3'd4;

    logic [2:0]          state_q,    state_d;
    logic                write_q,    write_d;
    logic [c_line_w-1:0] line_q,     line_d;
    logic [c_off_w-1:0]  beat_q,     beat_d;
    logic [c_lat_w-1:0]  lat_q,      lat_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    // Words never written read back as their own byte address, so only a
    // per-word "written" flag needs a power-up value; the array itself does not.
    logic [DATA_W-1:0]      mem_q [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] written_q = '0;

    logic [c_line_w-1:0] w_req_line;
    logic [c_off_w-1:0]  w_beat_inc;
    logic [c_idx_w-1:0]  w_rd_idx;
    logic [c_idx_w+1:0]  w_rd_byte;
    logic [DATA_W-1:0]   w_rd_word;
    logic [c_idx_w-1:0]  w_wr_idx;
    logic                w_wr_fire;
    logic                w_unused_addr;

    // Upper address bits alias and the in-line offset rounds down to the line start.
    assign w_req_line    = bus.req_addr[c_idx_w+1:c_off_w+2];
    assign w_unused_addr = ^{bus.req_addr[ADDR_W-1:c_idx_w+2], bus.req_addr[c_off_w+1:0]};
    assign w_beat_inc    = beat_q + 1'b1;

    // Read port always points at the word that the next rsp_data load needs.
    always_comb begin
        w_rd_idx = {line_q, w_beat_inc};
        case (state_q)
            c_st_idle: w_rd_idx = {w_req_line, {c_off_w{1'b0}}};
            c_st_wait: w_rd_idx = {line_q, {c_off_w{1'b0}}};
            default:   w_rd_idx = {line_q, w_beat_inc};
        endcase
    end

    assign w_rd_byte = {w_rd_idx, 2'b00};
    assign w_rd_word = written_q[w_rd_idx] ? mem_q[w_rd_idx] : DATA_W'(w_rd_byte);

    assign w_wr_fire = (state_q == c_st_wr_burst) && bus.wr_valid;
    assign w_wr_idx  = {line_q, beat_q};

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        line_d     = line_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            c_st_idle: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    line_d  = w_req_line;
                    beat_d  = '0;
                    lat_d   = '0;
                    if (LATENCY > 0) begin
                        state_d = c_st_wait;
                    end else if (bus.req_write) begin
                        state_d = c_st_wr_burst;
                    end else begin
                        state_d    = c_st_rd_burst;
                        rsp_data_d = w_rd_word;
                    end
                end
            end
            c_st_wait: begin
                if (lat_q == c_lat_last) begin
                    if (write_q) begin
                        state_d = c_st_wr_burst;
                    end else begin
                        state_d    = c_st_rd_burst;
                        rsp_data_d = w_rd_word;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            c_st_rd_burst: begin
                // rsp_data only moves on a transfer, which keeps it stable under stall.
                if (bus.rsp_ready) begin
                    if (beat_q == c_beat_last) begin
                        state_d = c_st_idle;
                    end else begin
                        beat_d     = w_beat_inc;
                        rsp_data_d = w_rd_word;
                    end
                end
            end
            c_st_wr_burst: begin
                if (bus.wr_valid) begin
                    beat_d = w_beat_inc;
                    if (beat_q == c_beat_last) begin
                        state_d = c_st_wr_ack;
                    end
                end
            end
            c_st_wr_ack: begin
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_st_idle;
            write_q    <= 1'b0;
            line_q     <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            line_q     <= line_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Storage is deliberately outside the reset domain: an aborted write keeps
    // the beats that already landed.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            mem_q[w_wr_idx]     <= bus.wr_data;
            written_q[w_wr_idx] <= 1'b1;
        end
    end

    assign bus.req_ready = (state_q == c_st_idle);
    assign bus.rsp_valid = (state_q == c_st_rd_burst);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = (state_q == c_st_rd_burst) && (beat_q == c_beat_last);
    assign bus.wr_ready  = (state_q == c_st_wr_burst);
    assign bus.wr_done   = (state_q == c_st_wr_ack);
    assign bus.busy      = (state_q != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_line_fill_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_fill_memory
//  Description : Directed line read/write scenarios with a queued scoreboard
//                for read beats and a monitor for accepts and write completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fill_memory;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WPL    = 16;
    localparam int DEPTH  = 1024;
    localparam int LAT    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_fill_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    line_fill_memory #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .WORDS_PER_LINE (WPL),
        .DEPTH_WORDS    (DEPTH),
        .LATENCY        (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    int                n_checks  = 0;
    int                n_errors  = 0;
    int                acc_cnt   = 0;
    int                done_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every valid read beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_valid && bus.req_ready) acc_cnt++;
            if (bus.wr_done) done_cnt++;
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp_beat", {31'd0, bus.rsp_valid}, 32'd0);
                end else begin
                    check("rsp_data", bus.rsp_data, exp_q[0].data);
                    check("rsp_last", {31'd0, bus.rsp_last}, {31'd0, exp_q[0].last});
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    function automatic int unsigned line_base(input logic [31:0] addr);
        return ((addr >> 2) % DEPTH) & ~(WPL - 1);
    endfunction

    task automatic issue_req(input logic wr, input logic [31:0] addr, input bit hold, input string tag);
        int n;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        check({tag, "_req_ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        check({tag, "_busy_after_accept"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_req_ready_after_accept"}, {31'd0, bus.req_ready}, 32'd0);
        n = 1;
        while (!(wr ? bus.wr_ready : bus.rsp_valid) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_first_beat_cycle"}, n, LAT + 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int mode, input bit hold, input string tag);
        int unsigned base;
        int beats, cyc, acc0;
        base = line_base(addr);
        for (int k = 0; k < WPL; k++) exp_q.push_back('{model[base + k], (k == WPL - 1)});
        acc0 = acc_cnt;
        issue_req(1'b0, addr, hold, tag);
        beats = 0;
        cyc   = 0;
        while (beats < WPL && cyc < 200) begin
            bus.rsp_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (hold) check({tag, "_no_accept_while_busy"}, {31'd0, bus.req_ready}, 32'd0);
            if (bus.rsp_valid && bus.rsp_ready) beats++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check({tag, "_beats"}, beats, WPL);
        if (mode == 0) check({tag, "_burst_cycles"}, cyc, WPL);
        check({tag, "_req_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, "_rsp_valid_after"}, {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_accepts"}, acc_cnt - acc0, 1);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] dbase, input int abort_after, input string tag);
        int unsigned base;
        int beats, cyc, d0;
        base = line_base(addr);
        d0   = done_cnt;
        issue_req(1'b1, addr, 1'b0, tag);
        beats = 0;
        cyc   = 0;
        while (beats < WPL && cyc < 200) begin
            if (abort_after != 0 && beats == abort_after) break;
            bus.wr_valid = ((cyc % 3) != 2);
            bus.wr_data  = dbase + beats;
            if (bus.wr_valid && bus.wr_ready) begin
                model[base + beats] = bus.wr_data;
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.wr_valid = 1'b0;
        if (abort_after != 0) begin
            check({tag, "_beats_before_abort"}, beats, abort_after);
            rst = 1'b1;
            #1;
            check({tag, "_rst_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
            check({tag, "_rst_busy"}, {31'd0, bus.busy}, 32'd0);
            check({tag, "_rst_wr_ready"}, {31'd0, bus.wr_ready}, 32'd0);
            check({tag, "_rst_wr_done"}, {31'd0, bus.wr_done}, 32'd0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk); #1;
            check({tag, "_idle_after_rst"}, {31'd0, bus.req_ready}, 32'd1);
            check({tag, "_no_done_pulse"}, done_cnt - d0, 0);
        end else begin
            check({tag, "_beats"}, beats, WPL);
            check({tag, "_wr_done_high"}, {31'd0, bus.wr_done}, 32'd1);
            check({tag, "_wr_ready_after_last"}, {31'd0, bus.wr_ready}, 32'd0);
            @(posedge clk); #1;
            check({tag, "_wr_done_low"}, {31'd0, bus.wr_done}, 32'd0);
            check({tag, "_req_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
            check({tag, "_done_pulses"}, done_cnt - d0, 1);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = i * 4;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("reset_busy",      {31'd0, bus.busy},      32'd0);
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_wr_ready",  {31'd0, bus.wr_ready},  32'd0);
        check("reset_wr_done",   {31'd0, bus.wr_done},   32'd0);
        check("reset_rsp_data",  bus.rsp_data,           32'd0);

        do_read (32'h0000_0040, 0, 1'b0, "rd40");
        do_read (32'h0000_0080, 1, 1'b0, "rd80_bp");
        do_write(32'h0000_0200, 32'hDEAD_BEEF, 0, "wr200");
        do_read (32'h0000_0200, 0, 1'b0, "rd200");
        do_read (32'h0000_0104, 1, 1'b0, "rd104_unaligned");
        do_read (32'h0000_1040, 0, 1'b1, "rd1040_alias_hold");
        do_write(32'h0000_0300, 32'hA5A5_0000, 5, "wr300_abort");
        do_read (32'h0000_0300, 0, 1'b0, "rd300");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
